// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and counter sizing.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD       = 2'd0,
        RELEASE    = 2'd1,
        RUN        = 2'd2,
        ASSERT_SEQ = 2'd3
    } seq_state_e;

    function automatic int seq_cnt_width(input int hold_cycles, input int release_dly);
        int longest;
        longest = (hold_cycles > release_dly) ? hold_cycles : release_dly;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/rst_sequencer.sv
// Ordered domain reset sequencer with software reset handshake.
// Optional macro RST_SEQ_REVERSE_ASSERT_EN: software reset asserts domains one per cycle, highest index first.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int RELEASE_DLY = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SW_RST_REQ,
    output logic                   SW_RST_ACK,
    output logic [NUM_DOMAINS-1:0] DOM_RST_N,
    output logic                   SEQ_DONE
);

    localparam int CNT_W = seq_cnt_width(HOLD_CYCLES, RELEASE_DLY);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(RELEASE_DLY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    seq_state_e             state_q, state_nxt;
    logic [CNT_W-1:0]       cnt_q, cnt_nxt, cnt_sat;
    logic [IDX_W-1:0]       idx_q, idx_nxt, idx_inc;
    logic [NUM_DOMAINS-1:0] dom_q, dom_nxt;
    logic                   done_q, done_nxt;
    logic                   ack_q, ack_nxt;

    logic hold_end, rel_end, last_rel, accept;

    assign cnt_sat  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign idx_inc  = idx_q + 1'b1;
    assign hold_end = (state_q == HOLD) && (cnt_q == HOLD_LAST);
    assign rel_end  = (state_q == RELEASE) && (cnt_q == DLY_LAST);
    assign last_rel = (hold_end && (NUM_DOMAINS == 1)) ||
                      (rel_end && (int'(idx_q) == NUM_DOMAINS - 2));
    // A request still held on the final release edge is taken there, so RUN never shows SEQ_DONE.
    assign accept   = SW_RST_REQ && ((state_q == RUN) || last_rel);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            idx_q   <= idx_nxt;
            dom_q   <= dom_nxt;
            done_q  <= done_nxt;
            ack_q   <= ack_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            HOLD:    if (hold_end) state_nxt = (NUM_DOMAINS == 1) ? RUN : RELEASE;
            RELEASE: if (last_rel) state_nxt = RUN;
`ifdef RST_SEQ_REVERSE_ASSERT_EN
            ASSERT_SEQ: if (idx_q == '0) state_nxt = HOLD;
`endif
            default: ;
        endcase
        if (accept) begin
`ifdef RST_SEQ_REVERSE_ASSERT_EN
            state_nxt = (NUM_DOMAINS == 1) ? HOLD : ASSERT_SEQ;
`else
            state_nxt = HOLD;
`endif
        end
    end

    always_comb begin
        dom_nxt  = dom_q;
        done_nxt = done_q;
        ack_nxt  = 1'b0;
        cnt_nxt  = cnt_q;
        idx_nxt  = idx_q;
        case (state_q)
            HOLD: begin
                dom_nxt = '0;
                cnt_nxt = cnt_sat;
                if (hold_end) begin
                    dom_nxt[0] = 1'b1;
                    cnt_nxt    = '0;
                    idx_nxt    = '0;
                end
            end
            RELEASE: begin
                cnt_nxt = cnt_sat;
                if (rel_end) begin
                    dom_nxt[idx_inc] = 1'b1;
                    cnt_nxt          = '0;
                    idx_nxt          = idx_inc;
                end
            end
`ifdef RST_SEQ_REVERSE_ASSERT_EN
            ASSERT_SEQ: begin
                dom_nxt[idx_q] = 1'b0;
                idx_nxt        = idx_q - 1'b1;
                cnt_nxt        = '0;
            end
`endif
            default: ;
        endcase
        if (last_rel) done_nxt = 1'b1;
        if (accept) begin
            ack_nxt  = 1'b1;
            done_nxt = 1'b0;
            cnt_nxt  = '0;
`ifdef RST_SEQ_REVERSE_ASSERT_EN
            dom_nxt[NUM_DOMAINS-1] = 1'b0;
            idx_nxt                = IDX_W'(NUM_DOMAINS - 2);
`else
            dom_nxt = '0;
`endif
        end
    end

    assign DOM_RST_N  = dom_q;
    assign SEQ_DONE   = done_q;
    assign SW_RST_ACK = ack_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer at default parameters; follows RST_SEQ_REVERSE_ASSERT_EN if defined.
module tb_rst_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       SW_RST_REQ = 1'b0;
    logic       SW_RST_ACK;
    logic [2:0] DOM_RST_N;
    logic       SEQ_DONE;

    int n_chk  = 0;
    int n_fail = 0;
    int e      = 0;
    int origin = 0;

    rst_sequencer #(
        .NUM_DOMAINS(3),
        .HOLD_CYCLES(16),
        .RELEASE_DLY(4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .SW_RST_REQ(SW_RST_REQ),
        .SW_RST_ACK(SW_RST_ACK),
        .DOM_RST_N (DOM_RST_N),
        .SEQ_DONE  (SEQ_DONE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    // Packed observation: {ack, done, dom[2:0]}.
    function automatic logic [4:0] obs();
        return {SW_RST_ACK, SEQ_DONE, DOM_RST_N};
    endfunction

    // Expected outputs rel edges after the sequence origin: bit i at 16+4i, done at 24.
    function automatic logic [4:0] exp_seq(input int rel);
        logic [2:0] d;
        d = '0;
        for (int i = 0; i < 3; i++) if (rel >= 16 + 4 * i) d[i] = 1'b1;
        return {1'b0, (rel >= 24), d};
    endfunction

    task automatic chk(input string tag, input logic [4:0] o, input logic [4:0] x);
        n_chk++;
        assert (o === x) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, o, x);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        e++;
    endtask

    task automatic follow(input int org, input int last);
        while (e < last) begin
            tick();
            chk($sformatf("seq e=%0d", e), obs(), exp_seq(e - org));
        end
    endtask

    // Accept a software reset on the next edge; returns the edge the new HOLD count starts from.
    task automatic sw_accept(input string tag, output int org);
        SW_RST_REQ = 1'b1;
        tick();
`ifdef RST_SEQ_REVERSE_ASSERT_EN
        chk({tag, " accept"}, obs(), 5'b10011);
        SW_RST_REQ = 1'b0;
        tick();
        chk({tag, " drop1"}, obs(), 5'b00001);
        tick();
        chk({tag, " drop0"}, obs(), 5'b00000);
`else
        chk({tag, " accept"}, obs(), 5'b10000);
        SW_RST_REQ = 1'b0;
`endif
        org = e;
    endtask

    initial begin
        // Power-on reset held across edges
        tick();
        tick();
        chk("reset", obs(), 5'b00000);
        RST = 1'b0;
        e = 0;
        follow(0, 27);

        // Software reset in RUN
        sw_accept("sw run", origin);
        follow(origin, origin + 26);

        // Early request held through the release sequence
        RST = 1'b1;
        #1;
        chk("rst pulse", obs(), 5'b00000);
        RST = 1'b0;
        e = 0;
        follow(0, 4);
        SW_RST_REQ = 1'b1;
        follow(0, 23);
        sw_accept("early", origin);
        follow(origin, origin + 18);
        chk("mid before rst", obs(), 5'b00001);

        // Asynchronous reset mid-sequence
        RST = 1'b1;
        #1;
        chk("mid rst async", obs(), 5'b00000);
        #1;
        RST = 1'b0;
        e = 0;
        follow(0, 25);

        // Reset and request together in RUN: reset wins
        RST = 1'b1;
        SW_RST_REQ = 1'b1;
        #1;
        chk("rst+req async", obs(), 5'b00000);
        tick();
        chk("rst+req edge1", obs(), 5'b00000);
        tick();
        chk("rst+req edge2", obs(), 5'b00000);
        SW_RST_REQ = 1'b0;
        RST = 1'b0;
        e = 0;
        follow(0, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
